spi_boot_sequencer: RTL
=======================

Name: spi_boot_sequencer

Overview:
- Boot-time master for the external SPI storage bus; supplies the boot-side enable and data lines to the storage mux.
- After reset, issues one READ command plus a start address, streams NUM_WORDS 16-bit words, and writes each word into core memory.
- Raises o_isBooted when finished, which hands the storage bus to the mapped/JTAG owners.

Parameters:
- NUM_WORDS, 32768: number of 16-bit words streamed from storage (>=2).
- ADDR_W, 16: width of the storage address and of o_memAddr.
- READ_CMD, 8'h03: SPI read opcode, sent MSB first.
- START_ADDR, 16'h0000: storage byte address sent after the opcode.

Ports:
- i_clk  in  1  core clock; all shifting occurs on its rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- o_bootEn  out  1  boot enable to storage mux; high 1 cycle before the first shift, low as the last shift occurs.
- o_bootSDI  out  1  serial data to storage, MSB first.
- i_storeSDO  in  1  serial data from storage; sampled on rising i_clk.
- o_memAddr  out  ADDR_W  word index being written.
- o_memData  out  16  assembled word.
- o_memWr  out  1  one-cycle write strobe; no backpressure.
- o_isBooted  out  1  boot complete; sticky until reset.
- o_bootErr  out  1  checksum failure (see Optional Feature).

Behaviour:
- Reset (async, any time, including mid-stream): state IDLE; all outputs 0; counters and shift register cleared.
- Cycle numbering: cycle 1 = first rising edge after i_rst falls.
- States:
  - IDLE: 1 cycle, then SETUP.
  - SETUP (cycle 1): o_bootEn=1, o_bootSDI=READ_CMD[7].
  - CMD (cycles 2-9): o_bootSDI=READ_CMD[7-k] in CMD cycle k.
  - ADDR (cycles 10-25): START_ADDR MSB first.
  - DATA (cycles 26 to 25+16*NUM_WORDS): o_bootSDI=0; i_storeSDO shifted in MSB first at the edge ending each cycle.
  - DONE: o_bootEn=0, o_isBooted=1.
  - ERR: o_bootEn=0, o_bootErr=1, o_isBooted=0.
- SETUP holding the first command bit with o_bootEn high gives the mux one cycle of enable before SCK runs.
- o_bootEn stays high from cycle 1 through the final DATA cycle, then drops to 0.
- Word k: o_memWr=1 in cycle 26+16*(k+1), with o_memAddr=k and o_memData=the assembled word.
  - A separate hold register keeps the write valid while word k+1 shifts in.
- The last write coincides with o_bootEn falling.
- o_isBooted rises the cycle after the last write, i.e. cycle 27+16*NUM_WORDS.
- Bit counter is 4 bits, wrapping 15->0 per word; word counter is ADDR_W bits, terminal at NUM_WORDS-1 (no wrap).
- DONE and ERR are terminal; only i_rst leaves them.

Optional Feature:
- Macro: BOOT_CHECKSUM_EN.
- Defined:
  - Word NUM_WORDS-1 is a checksum and is not written: no o_memWr in cycle 26+16*NUM_WORDS.
  - It must equal the mod-2^16 sum of words 0..NUM_WORDS-2.
  - Match: DONE at the normal cycle.
  - Mismatch: ERR instead, with o_bootErr=1 and o_isBooted held at 0.
- Undefined: all NUM_WORDS words are written; no sum logic; o_bootErr tied 0.

Decomposition:
- Package storage_boot_pkg:
  - state enum {IDLE, SETUP, CMD, ADDR, DATA, DONE, ERR};
  - CMD_BITS=8, WORD_BITS=16, default READ_CMD.
- One sub-module, boot_shift_reg: 16-bit parallel-load / serial-out and serial-in shifter with a 4-bit bit counter and a word-complete pulse.
- The top level holds the FSM, word counter, write hold register and checksum.

Test Plan:
- NUM_WORDS=2; SDO streams 16'hA5C3 then 16'h0F0F.
  - o_bootEn high for cycles 1-57.
  - o_bootSDI sequence 0000_0011 then sixteen 0s.
  - o_memWr at cycle 42 (addr 0, 16'hA5C3) and cycle 58 (addr 1, 16'h0F0F).
  - o_isBooted=1 from cycle 59.
- SDO constant 1 with NUM_WORDS=4 -> four writes of 16'hFFFF at addrs 0-3; no extra strobes.
- Assert i_rst in cycle 30 (mid-DATA) -> all outputs 0 immediately; after release, sequence restarts from SETUP with no stale write.
- BOOT_CHECKSUM_EN, NUM_WORDS=3, words 16'h8000, 16'h8001, checksum 16'h0001 -> two writes, DONE, o_bootErr=0.
- BOOT_CHECKSUM_EN with checksum 16'h0002 -> ERR; o_bootErr=1 and o_isBooted=0 for 100 cycles after.
- Hold i_rst high for 20 cycles -> o_bootEn, o_memWr and o_isBooted stay 0 throughout.

Source files
------------

// File: rtl/spi_boot_sequencer_pkg.sv
// Shared types and constants for the SPI boot sequencer.
package storage_boot_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    CMD   = 3'd2,
    ADDR  = 3'd3,
    DATA  = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } boot_state_e;

  localparam int         CMD_BITS     = 8;
  localparam int         WORD_BITS    = 16;
  localparam logic [7:0] DEF_READ_CMD = 8'h03;

  // Running checksum is a plain mod-2^16 sum of the streamed words.
  function automatic logic [WORD_BITS-1:0] csum_add(input logic [WORD_BITS-1:0] acc,
                                                    input logic [WORD_BITS-1:0] word);
    return acc + word;
  endfunction

endpackage

// File: rtl/spi_boot_sequencer_if.sv
// Storage-side serial lines plus core-memory write port of the boot sequencer.
// master = the sequencer, slave = storage device / memory / bus owners.
interface spi_boot_sequencer_if #(parameter int ADDR_W = 16) ();
  logic              o_bootEn;
  logic              o_bootSDI;
  logic              i_storeSDO;
  logic [ADDR_W-1:0] o_memAddr;
  logic [15:0]       o_memData;
  logic              o_memWr;
  logic              o_isBooted;
  logic              o_bootErr;

  modport master (
    output o_bootEn, o_bootSDI, o_memAddr, o_memData, o_memWr, o_isBooted, o_bootErr,
    input  i_storeSDO
  );

  modport slave (
    input  o_bootEn, o_bootSDI, o_memAddr, o_memData, o_memWr, o_isBooted, o_bootErr,
    output i_storeSDO
  );
endinterface

// File: rtl/spi_boot_sequencer_shift_reg.sv
// 16-bit shifter: parallel load, MSB-first serial out, serial in at bit 0.
// A 4-bit bit counter wraps 15->0; o_wordDone flags the shift that completes a word.
module boot_shift_reg
  import storage_boot_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_load,
  input  logic [WORD_BITS-1:0] i_loadVal,
  input  logic                 i_shift,
  input  logic                 i_sin,
  output logic [WORD_BITS-1:0] o_shNext,
  output logic [3:0]           o_bitCnt,
  output logic                 o_wordDone
);

  logic [WORD_BITS-1:0] sh_q, sh_d;
  logic [3:0]           cnt_q, cnt_d;

  // Next shifter contents: load has priority over shift.
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (i_load) begin
      sh_d  = i_loadVal;
      cnt_d = 4'd0;
    end else if (i_shift) begin
      sh_d  = {sh_q[WORD_BITS-2:0], i_sin};
      cnt_d = cnt_q + 4'd1;
    end else begin
      sh_d  = sh_q;
      cnt_d = cnt_q;
    end
  end

  // Shifter and bit counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sh_q  <= 16'h0000;
      cnt_q <= 4'd0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign o_shNext   = sh_d;
  assign o_bitCnt   = cnt_q;
  assign o_wordDone = i_shift && !i_load && (cnt_q == 4'd15);

endmodule

// File: rtl/spi_boot_sequencer.sv
// SPI boot sequencer: sends READ_CMD + START_ADDR, streams NUM_WORDS words
// into core memory, then flags boot complete.
// Optional: define BOOT_CHECKSUM_EN to treat the last word as a checksum.
module spi_boot_sequencer
  import storage_boot_pkg::*;
#(
  parameter int          NUM_WORDS  = 32768,
  parameter int          ADDR_W     = 16,
  parameter logic [7:0]  READ_CMD   = DEF_READ_CMD,
  parameter logic [15:0] START_ADDR = 16'h0000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  spi_boot_sequencer_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);

  boot_state_e       state_q, state_d;
  logic [ADDR_W-1:0] wordCnt_q, wordCnt_d;
  logic              lastWord_s;

  logic              shLoad_s, shShift_s, wordDone_s;
  logic [15:0]       shLoadVal_s, shNext_s;
  logic [3:0]        bitCnt_s;

  logic              bootEn_q, bootEn_d;
  logic              bootSDI_q, bootSDI_d;
  logic              memWr_q, memWr_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [15:0]       memData_q, memData_d;
  logic              isBooted_q, isBooted_d;
  logic              writeOk_s;
`ifdef BOOT_CHECKSUM_EN
  logic [15:0]       sum_q, sum_d;
  logic              bootErr_q, bootErr_d;
`endif

  assign lastWord_s = (wordCnt_q == LAST_WORD);

  boot_shift_reg u_shift (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (shLoad_s),
    .i_loadVal  (shLoadVal_s),
    .i_shift    (shShift_s),
    .i_sin      (bus.i_storeSDO),
    .o_shNext   (shNext_s),
    .o_bitCnt   (bitCnt_s),
    .o_wordDone (wordDone_s)
  );

  // State, word counter and checksum registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      wordCnt_q <= {ADDR_W{1'b0}};
`ifdef BOOT_CHECKSUM_EN
      sum_q     <= 16'h0000;
`endif
    end else begin
      state_q   <= state_d;
      wordCnt_q <= wordCnt_d;
`ifdef BOOT_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  // Next state: fixed-length command/address phases, then word-counted data.
  always_comb begin
    state_d   = state_q;
    wordCnt_d = wordCnt_q;
`ifdef BOOT_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    case (state_q)
      IDLE:  state_d = SETUP;
      SETUP: state_d = CMD;
      CMD: begin
        if (bitCnt_s == 4'd7) state_d = ADDR;
        else                  state_d = CMD;
      end
      ADDR: begin
        if (bitCnt_s == 4'd15) state_d = DATA;
        else                   state_d = ADDR;
      end
      DATA: begin
        if (wordDone_s) begin
          if (lastWord_s) begin
`ifdef BOOT_CHECKSUM_EN
            if (shNext_s == sum_q) state_d = DONE;
            else                   state_d = ERR;
`else
            state_d = DONE;
`endif
          end else begin
            wordCnt_d = wordCnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
`ifdef BOOT_CHECKSUM_EN
            sum_d     = csum_add(sum_q, shNext_s);
`endif
          end
        end else begin
          state_d = DATA;
        end
      end
      DONE:    state_d = DONE;
      ERR:     state_d = ERR;
      default: state_d = IDLE;
    endcase
  end

  // Shifter control: load opcode, then address, then clear before data.
  always_comb begin
    shLoad_s    = 1'b0;
    shLoadVal_s = 16'h0000;
    shShift_s   = 1'b0;
    case (state_q)
      IDLE: begin
        shLoad_s    = 1'b1;
        shLoadVal_s = {READ_CMD, 8'h00};
      end
      CMD: begin
        if (bitCnt_s == 4'd7) begin
          shLoad_s    = 1'b1;
          shLoadVal_s = START_ADDR;
        end else begin
          shShift_s = 1'b1;
        end
      end
      ADDR: begin
        if (bitCnt_s == 4'd15) begin
          shLoad_s    = 1'b1;
          shLoadVal_s = 16'h0000;
        end else begin
          shShift_s = 1'b1;
        end
      end
      DATA:    shShift_s = 1'b1;
      default: shShift_s = 1'b0;
    endcase
  end

  // Output next values; the write hold registers keep addr/data between strobes.
  always_comb begin
`ifdef BOOT_CHECKSUM_EN
    writeOk_s = !lastWord_s;
    bootErr_d = (state_q == ERR);
`else
    writeOk_s = 1'b1;
`endif
    bootEn_d = (state_d inside {SETUP, CMD, ADDR, DATA});
    if (state_d inside {SETUP, CMD, ADDR}) bootSDI_d = shNext_s[15];
    else                                    bootSDI_d = 1'b0;
    memWr_d   = 1'b0;
    memAddr_d = memAddr_q;
    memData_d = memData_q;
    if ((state_q == DATA) && wordDone_s && writeOk_s) begin
      memWr_d   = 1'b1;
      memAddr_d = wordCnt_q;
      memData_d = shNext_s;
    end else begin
      memWr_d = 1'b0;
    end
    isBooted_d = (state_q == DONE);
  end

  // Registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bootEn_q   <= 1'b0;
      bootSDI_q  <= 1'b0;
      memWr_q    <= 1'b0;
      memAddr_q  <= {ADDR_W{1'b0}};
      memData_q  <= 16'h0000;
      isBooted_q <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      bootErr_q  <= 1'b0;
`endif
    end else begin
      bootEn_q   <= bootEn_d;
      bootSDI_q  <= bootSDI_d;
      memWr_q    <= memWr_d;
      memAddr_q  <= memAddr_d;
      memData_q  <= memData_d;
      isBooted_q <= isBooted_d;
`ifdef BOOT_CHECKSUM_EN
      bootErr_q  <= bootErr_d;
`endif
    end
  end

  assign bus.o_bootEn   = bootEn_q;
  assign bus.o_bootSDI  = bootSDI_q;
  assign bus.o_memWr    = memWr_q;
  assign bus.o_memAddr  = memAddr_q;
  assign bus.o_memData  = memData_q;
  assign bus.o_isBooted = isBooted_q;
`ifdef BOOT_CHECKSUM_EN
  assign bus.o_bootErr  = bootErr_q;
`else
  assign bus.o_bootErr  = 1'b0;
`endif

endmodule
